// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: decoder/pipeline status in, stage enables, flushes,
// FSM state and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [1:0]       id_dep_check;
  logic             ex_valid;
  logic             ex_wen;
  logic             ex_is_load;
  logic [4:0]       ex_rd;
  logic             mem_valid;
  logic             mem_wen;
  logic [4:0]       mem_rd;
  logic             ex_redirect;
  logic             imem_ready;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_valid, id_rs1, id_rs2, id_dep_check,
    output ex_valid, ex_wen, ex_is_load, ex_rd,
    output mem_valid, mem_wen, mem_rd,
    output ex_redirect, imem_ready, dmem_req, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, state, stall_cycles, flush_events
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_dep_check,
    input  ex_valid, ex_wen, ex_is_load, ex_rd,
    input  mem_valid, mem_wen, mem_rd,
    input  ex_redirect, imem_ready, dmem_req, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, state, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stage enables,
// bubbles and counters. Define PIPE_HAZARD_FWD_EN when the datapath forwards.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   ctrl
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic w_hz_ex, w_hz_mem, w_lu, w_mw, w_stall;
  logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic w_if_id_flush, w_id_ex_flush;
  logic w_stall_inc, w_flush_inc;

  function automatic logic hz(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [1:0] dep);
    return (rd != 5'd0) && ((dep[1] && (rd == rs1)) || (dep[0] && (rd == rs2)));
  endfunction

  assign w_hz_ex  = hz(ctrl.ex_rd,  ctrl.id_rs1, ctrl.id_rs2, ctrl.id_dep_check);
  assign w_hz_mem = hz(ctrl.mem_rd, ctrl.id_rs1, ctrl.id_rs2, ctrl.id_dep_check);
  assign w_lu     = ctrl.id_valid & ctrl.ex_valid & ctrl.ex_wen & ctrl.ex_is_load & w_hz_ex;
  assign w_mw     = ctrl.dmem_req & ~ctrl.dmem_ready;

`ifdef PIPE_HAZARD_FWD_EN
  assign w_stall = w_lu;
`else
  // Without forwarding any in-flight producer of a read register stalls ID;
  // WB needs no check because the regfile is write-first.
  assign w_stall = w_lu
                 | (ctrl.id_valid & ctrl.ex_valid  & ctrl.ex_wen  & w_hz_ex)
                 | (ctrl.id_valid & ctrl.mem_valid & ctrl.mem_wen & w_hz_mem);
`endif

  always_comb begin
    // NOTE: every signal gets its default first so no branch can infer a latch.
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_ex_mem_en   = 1'b1;
    w_mem_wb_en   = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_state_nxt   = ST_RUN;

    if (w_mw) begin
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
      w_stall_inc = 1'b1;
      w_state_nxt = ST_MEM_WAIT;
    end else if (ctrl.ex_redirect) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
      w_flush_inc   = 1'b1;
      w_state_nxt   = ST_FLUSH;
    end else if (w_stall) begin
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_flush = 1'b1;
      w_stall_inc   = 1'b1;
      w_state_nxt   = ST_LU_STALL;
    end else if (!ctrl.imem_ready) begin
      w_pc_en       = 1'b0;
      w_if_id_flush = 1'b1;
      w_stall_inc   = 1'b1;
    end

    // Squash the wrong-path fetch that lands one cycle after a redirect,
    // unless a memory wait is holding that instruction in place.
    if ((r_state == ST_FLUSH) && !w_mw) begin
      w_if_id_flush = 1'b1;
    end

    if (!rst_n) begin
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_en    = 1'b0;
      w_ex_mem_en   = 1'b0;
      w_mem_wb_en   = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall_inc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign ctrl.pc_en        = w_pc_en;
  assign ctrl.if_id_en     = w_if_id_en;
  assign ctrl.id_ex_en     = w_id_ex_en;
  assign ctrl.ex_mem_en    = w_ex_mem_en;
  assign ctrl.mem_wb_en    = w_mem_wb_en;
  assign ctrl.if_id_flush  = w_if_id_flush;
  assign ctrl.id_ex_flush  = w_id_ex_flush;
  assign ctrl.state        = r_state;
  assign ctrl.stall_cycles = r_stall_cycles;
  assign ctrl.flush_events = r_flush_events;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  // Model state: expected FSM state number and counter values.
  int m_state = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hz(input logic [4:0] rd);
    logic [4:0] src [2];
    bit hit = 1'b0;
    src[0] = bus.id_rs1;
    src[1] = bus.id_rs2;
    for (int i = 0; i < 2; i++) begin
      if (bus.id_dep_check[1-i] && rd != 0 && rd == src[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Situation class, highest priority wins:
  // 4 memory wait, 3 redirect, 2 ID stall, 1 fetch miss, 0 normal flow.
  function automatic int m_cls();
    bit ex_prod, mem_prod, stall;
    ex_prod  = bus.id_valid && bus.ex_valid && bus.ex_wen && m_hz(bus.ex_rd);
    mem_prod = bus.id_valid && bus.mem_valid && bus.mem_wen && m_hz(bus.mem_rd);
`ifdef PIPE_HAZARD_FWD_EN
    stall = ex_prod && bus.ex_is_load;
`else
    stall = ex_prod || mem_prod;
`endif
    if (bus.dmem_req && !bus.dmem_ready) return 4;
    if (bus.ex_redirect)                 return 3;
    if (stall)                           return 2;
    if (!bus.imem_ready)                 return 1;
    return 0;
  endfunction

  // Enables {pc,if_id,id_ex,ex_mem,mem_wb}: the first 'frozen' stages hold.
  function automatic logic [4:0] m_en();
    int frozen;
    logic [4:0] v = '0;
    if (!rst_n) return 5'b00000;
    case (m_cls())
      4: frozen = 5;
      2: frozen = 2;
      1: frozen = 1;
      default: frozen = 0;
    endcase
    for (int i = 0; i < 5; i++) v[4-i] = (i >= frozen);
    return v;
  endfunction

  // Bubbles {if_id_flush, id_ex_flush}.
  function automatic logic [1:0] m_fl();
    int c;
    logic [1:0] f;
    if (!rst_n) return 2'b11;
    c = m_cls();
    f = (c == 3) ? 2'b11 : (c == 2) ? 2'b01 : (c == 1) ? 2'b10 : 2'b00;
    if (m_state == 2 && c != 4) f[1] = 1'b1;
    return f;
  endfunction

  always @(posedge clk) begin
    int c;
    if (!rst_n) begin
      m_state = 0;
      m_stall = 0;
      m_flush = 0;
    end else begin
      c = m_cls();
      m_state = (c == 4) ? 3 : (c == 3) ? 2 : (c == 2) ? 1 : 0;
      if (c == 4 || c == 2 || c == 1) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (c == 3)                     m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_en", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, m_en());
      check("model_flush", {bus.if_id_flush, bus.id_ex_flush}, m_fl());
      check("model_state", bus.state, m_state);
      check("model_stall_cycles", bus.stall_cycles, m_stall);
      check("model_flush_events", bus.flush_events, m_flush);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid     = 1'b1;
    bus.id_rs1       = 5'd1;
    bus.id_rs2       = 5'd2;
    bus.id_dep_check = 2'b00;
    bus.ex_valid     = 1'b0;
    bus.ex_wen       = 1'b0;
    bus.ex_is_load   = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.mem_valid    = 1'b0;
    bus.mem_wen      = 1'b0;
    bus.mem_rd       = 5'd0;
    bus.ex_redirect  = 1'b0;
    bus.imem_ready   = 1'b1;
    bus.dmem_req     = 1'b0;
    bus.dmem_ready   = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [1:0] dep);
    idle();
    bus.ex_valid = 1'b1; bus.ex_wen = 1'b1; bus.ex_is_load = 1'b1;
    bus.ex_rd = rd; bus.id_rs1 = 5'd5; bus.id_dep_check = dep;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    tick();
    chk_en = 1'b1;

    // Load-use: one bubble, LU_STALL next cycle, one stall counted.
    do_reset();
    load_use(5'd5, 2'b10);
    at_neg();
    check("lu_en", {bus.pc_en, bus.if_id_en, bus.id_ex_en}, 3'b001);
    check("lu_id_ex_flush", bus.id_ex_flush, 1'b1);
    tick(); idle(); at_neg();
    check("lu_state", bus.state, 2'd1);
    check("lu_stall_cycles", bus.stall_cycles, 4'd1);
    check("lu_release", bus.pc_en, 1'b1);

    // No false hazards.
    do_reset();
    load_use(5'd5, 2'b00);
    at_neg();
    check("nofalse_dep_pc_en", bus.pc_en, 1'b1);
    tick(); load_use(5'd0, 2'b10); at_neg();
    check("nofalse_dep_state", bus.state, 2'd0);
    check("nofalse_x0_pc_en", bus.pc_en, 1'b1);
    tick(); idle(); at_neg();
    check("nofalse_x0_state", bus.state, 2'd0);

    // Redirect: two bubbles.
    do_reset();
    bus.ex_redirect = 1'b1;
    at_neg();
    check("redir_flush", {bus.if_id_flush, bus.id_ex_flush}, 2'b11);
    tick(); idle(); at_neg();
    check("redir_state", bus.state, 2'd2);
    check("redir_flush_state_if_id", {bus.if_id_flush, bus.id_ex_flush}, 2'b10);
    check("redir_flush_events", bus.flush_events, 4'd1);
    tick(); at_neg();
    check("redir_after", {bus.state, bus.if_id_flush}, 3'b000);

    // Memory wait for 3 cycles, then advance.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
      at_neg();
      check("mw_en", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 5'b00000);
      if (i > 0) check("mw_state", bus.state, 2'd3);
      tick();
    end
    bus.dmem_ready = 1'b1;
    at_neg();
    check("mw_advance", {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en}, 5'b11111);
    tick(); idle(); at_neg();
    check("mw_stall_cycles", bus.stall_cycles, 4'd3);
    check("mw_state_run", bus.state, 2'd0);

    // Redirect held behind a memory wait.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.ex_redirect = 1'b1; bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
      at_neg();
      check("rmw_hold", {bus.pc_en, bus.if_id_flush, bus.id_ex_flush}, 3'b000);
      tick();
    end
    bus.dmem_ready = 1'b1;
    at_neg();
    check("rmw_release_flush", {bus.if_id_flush, bus.id_ex_flush}, 2'b11);
    tick(); idle(); at_neg();
    check("rmw_state", bus.state, 2'd2);
    check("rmw_flush_events", bus.flush_events, 4'd1);

    // Reset while in FLUSH discards the pending squash.
    do_reset();
    bus.ex_redirect = 1'b1;
    tick(); idle(); rst_n = 1'b0; at_neg();
    check("rst_outputs", {bus.pc_en, bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush}, 4'b0011);
    tick(); rst_n = 1'b1; at_neg();
    check("rst_state", bus.state, 2'd0);
    check("rst_counters", {bus.stall_cycles, bus.flush_events}, 8'h00);
    check("rst_no_squash", bus.if_id_flush, 1'b0);

    // ALU producer in MEM feeding rs2.
    do_reset();
    bus.mem_valid = 1'b1; bus.mem_wen = 1'b1; bus.mem_rd = 5'd7;
    bus.id_rs2 = 5'd7; bus.id_dep_check = 2'b01;
    at_neg();
`ifdef PIPE_HAZARD_FWD_EN
    check("mem_prod_fwd_pc_en", bus.pc_en, 1'b1);
    tick(); idle(); at_neg();
    check("mem_prod_fwd_state", bus.state, 2'd0);
`else
    check("mem_prod_stall", {bus.pc_en, bus.if_id_en, bus.id_ex_flush}, 3'b001);
    tick(); idle(); at_neg();
    check("mem_prod_state", bus.state, 2'd1);
    check("mem_prod_release", bus.pc_en, 1'b1);
`endif

    // Counter saturation.
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    repeat (CMAX + 3) tick();
    idle(); at_neg();
    check("sat_stall_cycles", bus.stall_cycles, 4'hF);

    // Randomized traffic with small register indices to make hazards common.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n            = ($urandom_range(0, 59) != 0);
      bus.id_valid     = ($urandom_range(0, 7) != 0);
      bus.id_rs1       = 5'($urandom_range(0, 3));
      bus.id_rs2       = 5'($urandom_range(0, 3));
      bus.id_dep_check = 2'($urandom_range(0, 3));
      bus.ex_valid     = $urandom_range(0, 1) == 1;
      bus.ex_wen       = $urandom_range(0, 3) != 0;
      bus.ex_is_load   = $urandom_range(0, 1) == 1;
      bus.ex_rd        = 5'($urandom_range(0, 3));
      bus.mem_valid    = $urandom_range(0, 1) == 1;
      bus.mem_wen      = $urandom_range(0, 3) != 0;
      bus.mem_rd       = 5'($urandom_range(0, 3));
      bus.ex_redirect  = $urandom_range(0, 5) == 0;
      bus.imem_ready   = $urandom_range(0, 4) != 0;
      bus.dmem_req     = $urandom_range(0, 2) == 0;
      bus.dmem_ready   = $urandom_range(0, 2) != 0;
      tick();
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
